// File: rtl/bsg_gateway_power_seq.sv
// bsg_gateway_power_seq
//
// Board bring-up sequencer for the gateway FPGA. Ramps the ASIC I/O rail, then
// the core rail, releases the digital-pot reset, pulses the comm-link reset and
// waits for link calibration, retrying a bounded number of times on timeout.
// Dropping en_i runs an ordered power-down (core rail first, I/O rail later).
//
// Ports:
//   clk_i          - sole clock
//   reset_n_i      - synchronous active-low reset
//   en_i           - level request: 1 = power up and run, 0 = power down
//   calib_done_i   - comm-link calibration done (synchronous to clk_i)
//   asic_io_en_o   - I/O rail enable
//   asic_core_en_o - core rail enable
//   dig_pot_nrst_o - digital-pot reset, active-low
//   link_reset_o   - comm-link reset, active-high
//   running_o      - sequencer is in RUN
//   fail_o         - sequencer is in FAIL
//   state_o        - current state encoding
//   retry_count_o  - link retries consumed
//
// Optional feature macro: BSG_GATEWAY_POWER_SEQ_AUTO_RELINK_EN
//   defined     - losing calib_done_i in RUN re-enters LINK_RST (counts a retry,
//                 or goes to FAIL once retries are exhausted)
//   not defined - losing calib_done_i in RUN goes straight to FAIL
//
// Every output is a flop fed from a decode of the state register, so outputs
// trail the internal state by one cycle and no input reaches an output
// combinationally.

module bsg_gateway_power_seq #(
  parameter int unsigned io_settle_cycles_p     = 1000,
  parameter int unsigned core_settle_cycles_p   = 1000,
  parameter int unsigned link_reset_cycles_p    = 64,
  parameter int unsigned calib_timeout_cycles_p = 1048576,
  parameter int unsigned max_retries_p          = 3
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic       calib_done_i,
  output logic       asic_io_en_o,
  output logic       asic_core_en_o,
  output logic       dig_pot_nrst_o,
  output logic       link_reset_o,
  output logic       running_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [((max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1)-1:0] retry_count_o
);

  localparam int unsigned retry_w_lp =
    (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1;

  localparam int unsigned max_ab_lp =
    (io_settle_cycles_p > core_settle_cycles_p) ? io_settle_cycles_p : core_settle_cycles_p;
  localparam int unsigned max_cd_lp =
    (link_reset_cycles_p > calib_timeout_cycles_p) ? link_reset_cycles_p : calib_timeout_cycles_p;
  localparam int unsigned max_cyc_lp = (max_ab_lp > max_cd_lp) ? max_ab_lp : max_cd_lp;
  localparam int unsigned cnt_w_lp =
    (max_cyc_lp > 1) ? $clog2(max_cyc_lp + 1) : 1;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_IO_RAMP   = 3'd1,
    ST_CORE_RAMP = 3'd2,
    ST_LINK_RST  = 3'd3,
    ST_CALIB     = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6,
    ST_DOWN      = 3'd7
  } state_e;

  localparam logic [retry_w_lp-1:0] max_retry_lp = retry_w_lp'(max_retries_p);

  // The counter is loaded with N-1 on entry and the state is left on the edge
  // that sees it at zero, giving exactly N cycles in the state.
  function automatic logic [cnt_w_lp-1:0] load_f(input int unsigned n);
    return (n == 0) ? '0 : cnt_w_lp'(n - 1);
  endfunction

  state_e                state_q, state_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic [retry_w_lp-1:0] retry_q, retry_d;

  logic                  io_en_q, io_en_d;
  logic                  core_en_q, core_en_d;
  logic                  pot_nrst_q, pot_nrst_d;
  logic                  link_rst_q, link_rst_d;
  logic                  running_q, running_d;
  logic                  fail_q, fail_d;
  logic [2:0]            state_out_q, state_out_d;
  logic [retry_w_lp-1:0] retry_out_q, retry_out_d;

  logic cnt_zero;
  assign cnt_zero = (cnt_q == '0);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_zero ? '0 : cnt_q - 1'b1;

    unique case (state_q)
      ST_OFF: begin
        if (en_i) begin
          state_d = ST_IO_RAMP;
          retry_d = '0;
        end
      end
      ST_IO_RAMP:   if (cnt_zero) state_d = ST_CORE_RAMP;
      ST_CORE_RAMP: if (cnt_zero) state_d = ST_LINK_RST;
      ST_LINK_RST:  if (cnt_zero) state_d = ST_CALIB;
      ST_CALIB: begin
        if (calib_done_i) begin
          state_d = ST_RUN;
        end else if (cnt_zero) begin
          if (retry_q < max_retry_lp) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_LINK_RST;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_RUN: begin
        if (!calib_done_i) begin
`ifdef BSG_GATEWAY_POWER_SEQ_AUTO_RELINK_EN
          if (retry_q < max_retry_lp) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_LINK_RST;
          end else begin
            state_d = ST_FAIL;
          end
`else
          state_d = ST_FAIL;
`endif
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      ST_DOWN: if (cnt_zero) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase

    // Power-down request overrides any transition chosen above, including a
    // retry increment that would otherwise have been taken this cycle.
    if (!en_i && (state_q != ST_OFF) && (state_q != ST_DOWN)) begin
      state_d = ST_DOWN;
      retry_d = retry_q;
    end

    if (state_d != state_q) begin
      unique case (state_d)
        ST_IO_RAMP:   cnt_d = load_f(io_settle_cycles_p);
        ST_CORE_RAMP: cnt_d = load_f(core_settle_cycles_p);
        ST_LINK_RST:  cnt_d = load_f(link_reset_cycles_p);
        ST_CALIB:     cnt_d = load_f(calib_timeout_cycles_p);
        ST_DOWN:      cnt_d = load_f(core_settle_cycles_p);
        default:      cnt_d = '0;
      endcase
    end
  end

  // Output decode of the current state register
  always_comb begin
    io_en_d     = (state_q != ST_OFF);
    core_en_d   = (state_q >= ST_CORE_RAMP) && (state_q <= ST_FAIL);
    pot_nrst_d  = (state_q >= ST_LINK_RST) && (state_q <= ST_FAIL);
    link_rst_d  = !((state_q == ST_CALIB) || (state_q == ST_RUN));
    running_d   = (state_q == ST_RUN);
    fail_d      = (state_q == ST_FAIL);
    state_out_d = state_q;
    retry_out_d = retry_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      retry_q     <= '0;
      io_en_q     <= 1'b0;
      core_en_q   <= 1'b0;
      pot_nrst_q  <= 1'b0;
      link_rst_q  <= 1'b1;
      running_q   <= 1'b0;
      fail_q      <= 1'b0;
      state_out_q <= '0;
      retry_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      io_en_q     <= io_en_d;
      core_en_q   <= core_en_d;
      pot_nrst_q  <= pot_nrst_d;
      link_rst_q  <= link_rst_d;
      running_q   <= running_d;
      fail_q      <= fail_d;
      state_out_q <= state_out_d;
      retry_out_q <= retry_out_d;
    end
  end

  assign asic_io_en_o   = io_en_q;
  assign asic_core_en_o = core_en_q;
  assign dig_pot_nrst_o = pot_nrst_q;
  assign link_reset_o   = link_rst_q;
  assign running_o      = running_q;
  assign fail_o         = fail_q;
  assign state_o        = state_out_q;
  assign retry_count_o  = retry_out_q;

endmodule

// File: tb/tb_bsg_gateway_power_seq.sv
// tb_bsg_gateway_power_seq
//
// Directed bench for bsg_gateway_power_seq with short timing parameters.
// A cycle-level behavioural model (state timeline with elapsed-cycle counts and
// a duration table) predicts every output each cycle; hand-computed literal
// checks at specific cycles pin the model to the intended timeline.

module tb_bsg_gateway_power_seq;

  localparam int unsigned IO_P    = 4;
  localparam int unsigned CORE_P  = 3;
  localparam int unsigned LINK_P  = 2;
  localparam int unsigned CALIB_P = 8;
  localparam int unsigned RETRY_P = 2;

  logic       clk = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       en_i = 1'b0;
  logic       calib_done_i = 1'b0;
  logic       asic_io_en_o, asic_core_en_o, dig_pot_nrst_o, link_reset_o;
  logic       running_o, fail_o;
  logic [2:0] state_o;
  logic [1:0] retry_count_o;

  bsg_gateway_power_seq #(
    .io_settle_cycles_p    (IO_P),
    .core_settle_cycles_p  (CORE_P),
    .link_reset_cycles_p   (LINK_P),
    .calib_timeout_cycles_p(CALIB_P),
    .max_retries_p         (RETRY_P)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .en_i          (en_i),
    .calib_done_i  (calib_done_i),
    .asic_io_en_o  (asic_io_en_o),
    .asic_core_en_o(asic_core_en_o),
    .dig_pot_nrst_o(dig_pot_nrst_o),
    .link_reset_o  (link_reset_o),
    .running_o     (running_o),
    .fail_o        (fail_o),
    .state_o       (state_o),
    .retry_count_o (retry_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_no  = 0;
  int t0       = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: m_state is the sequencer's state after this edge,
  // vis_* is what the outputs show (the state from one edge earlier).
  int m_state = 0, m_el = 0, m_retry = 0;
  int vis_state = 0, vis_retry = 0;
  int dur [8] = '{0, IO_P, CORE_P, LINK_P, CALIB_P, 0, 0, CORE_P};

  always @(posedge clk) begin
    int nxt, nr;
    edge_no++;
    if (!reset_n_i) begin
      m_state = 0; m_el = 0; m_retry = 0; vis_state = 0; vis_retry = 0;
    end else begin
      vis_state = m_state;
      vis_retry = m_retry;
      nxt = m_state;
      nr  = m_retry;
      if (!en_i && m_state >= 1 && m_state <= 6) nxt = 7;
      else begin
        case (m_state)
          0: if (en_i) begin nxt = 1; nr = 0; end
          1, 2, 3: if (m_el + 1 >= dur[m_state]) nxt = m_state + 1;
          7: if (m_el + 1 >= dur[7]) nxt = 0;
          4: begin
            if (calib_done_i) nxt = 5;
            else if (m_el + 1 >= dur[4]) begin
              if (m_retry < RETRY_P) begin nr = m_retry + 1; nxt = 3; end
              else nxt = 6;
            end
          end
          5: if (!calib_done_i) begin
`ifdef BSG_GATEWAY_POWER_SEQ_AUTO_RELINK_EN
            if (m_retry < RETRY_P) begin nr = m_retry + 1; nxt = 3; end
            else nxt = 6;
`else
            nxt = 6;
`endif
          end
          default: nxt = m_state;
        endcase
      end
      m_el    = (nxt != m_state) ? 0 : m_el + 1;
      m_state = nxt;
      m_retry = nr;
    end
  end

  function automatic logic [10:0] model_outs(input int s, input int r);
    logic [2:0] s3;
    logic [1:0] r2;
    s3 = s[2:0];
    r2 = r[1:0];
    return {(s >= 1 && s <= 7), (s >= 2 && s <= 6), (s >= 3 && s <= 6),
            !(s == 4 || s == 5), (s == 5), (s == 6), s3, r2};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [10:0] got, exp;
    if (chk_en) begin
      got = {asic_io_en_o, asic_core_en_o, dig_pot_nrst_o, link_reset_o,
             running_o, fail_o, state_o, retry_count_o};
      exp = model_outs(vis_state, vis_retry);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL model_cmp edge=%0d got=%b exp=%b", edge_no, got, exp);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Wait until the negedge that follows edge k of the current scenario.
  task automatic at(input int k);
    while (edge_no < t0 + k) @(negedge clk);
  endtask

  // Called at a negedge: the next posedge is cycle 0 of a new scenario.
  task automatic start();
    t0 = edge_no + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_io",    32'(asic_io_en_o),   32'd0);
    chk("rst_core",  32'(asic_core_en_o), 32'd0);
    chk("rst_pot",   32'(dig_pot_nrst_o), 32'd0);
    chk("rst_lrst",  32'(link_reset_o),   32'd1);
    chk("rst_run",   32'(running_o),      32'd0);
    chk("rst_fail",  32'(fail_o),         32'd0);
    chk("rst_state", 32'(state_o),        32'd0);
    chk("rst_retry", 32'(retry_count_o),  32'd0);

    // Nominal bring-up
    reset_n_i = 1'b1; en_i = 1'b1; start();
    at(0);  chk("nom_io_c0",   32'(asic_io_en_o),   32'd0);
    at(1);  chk("nom_io_c1",   32'(asic_io_en_o),   32'd1);
    at(4);  chk("nom_core_c4", 32'(asic_core_en_o), 32'd0);
    at(5);  chk("nom_core_c5", 32'(asic_core_en_o), 32'd1);
    at(7);  chk("nom_pot_c7",  32'(dig_pot_nrst_o), 32'd0);
    at(8);  chk("nom_pot_c8",  32'(dig_pot_nrst_o), 32'd1);
    at(9);  chk("nom_lrst_c9", 32'(link_reset_o),   32'd1);
    at(10); chk("nom_lrst_c10", 32'(link_reset_o),  32'd0);
    at(11); calib_done_i = 1'b1;
    at(12); chk("nom_run_c12", 32'(running_o),      32'd0);
    at(13); chk("nom_run_c13", 32'(running_o),      32'd1);
            chk("nom_state_c13", 32'(state_o),      32'd5);

    // Run loss, then power-down overriding the LINK_RST expiry
    at(15); calib_done_i = 1'b0;
    at(17);
`ifdef BSG_GATEWAY_POWER_SEQ_AUTO_RELINK_EN
    chk("loss_state", 32'(state_o),       32'd3);
    chk("loss_retry", 32'(retry_count_o), 32'd1);
`else
    chk("loss_state", 32'(state_o),        32'd6);
    chk("loss_fail",  32'(fail_o),         32'd1);
    chk("loss_core",  32'(asic_core_en_o), 32'd1);
`endif
    en_i = 1'b0;
    at(19); chk("pd_state_c19", 32'(state_o),        32'd7);
            chk("pd_core_c19",  32'(asic_core_en_o), 32'd0);
    at(21); chk("pd_io_c21",    32'(asic_io_en_o),   32'd1);
    at(22); chk("pd_io_c22",    32'(asic_io_en_o),   32'd0);

    // Retry exhaustion
    at(23); en_i = 1'b1; start();
    at(17); chk("rx_retry_c17", 32'(retry_count_o), 32'd0);
    at(18); chk("rx_state_c18", 32'(state_o),       32'd3);
            chk("rx_retry_c18", 32'(retry_count_o), 32'd1);
    at(28); chk("rx_state_c28", 32'(state_o),       32'd3);
            chk("rx_retry_c28", 32'(retry_count_o), 32'd2);
    at(37); chk("rx_fail_c37",  32'(fail_o),        32'd0);
    at(38); chk("rx_fail_c38",  32'(fail_o),        32'd1);
    at(42); chk("rx_fail_c42",  32'(state_o),       32'd6);
    en_i = 1'b0;
    at(44); chk("rx_down_c44",  32'(state_o),       32'd7);
            chk("rx_hold_c44",  32'(retry_count_o), 32'd2);
    at(47); chk("rx_off_c47",   32'(state_o),       32'd0);

    // Calibration arriving in the expiry cycle of the second attempt
    at(48); en_i = 1'b1; start();
    at(18); chk("sim_retry_c18", 32'(retry_count_o), 32'd1);
    at(26); calib_done_i = 1'b1;
    at(27); chk("sim_state_c27", 32'(state_o),       32'd4);
    at(28); chk("sim_state_c28", 32'(state_o),       32'd5);
            chk("sim_retry_c28", 32'(retry_count_o), 32'd1);
    at(30); en_i = 1'b0;
    at(35); chk("sim_off_c35",   32'(state_o),       32'd0);
    calib_done_i = 1'b0;

    // Abort during CORE_RAMP with en_i glitching high during DOWN
    at(36); en_i = 1'b1; start();
    at(4);  en_i = 1'b0;
    at(5);  chk("ab_core_c5",  32'(asic_core_en_o), 32'd1);
    at(6);  chk("ab_core_c6",  32'(asic_core_en_o), 32'd0);
            chk("ab_io_c6",    32'(asic_io_en_o),   32'd1);
            en_i = 1'b1;
    at(7);  en_i = 1'b0;
    at(8);  chk("ab_down_c8",  32'(state_o),        32'd7);
            chk("ab_io_c8",    32'(asic_io_en_o),   32'd1);
    at(9);  chk("ab_io_c9",    32'(asic_io_en_o),   32'd0);
    at(10); chk("ab_off_c10",  32'(state_o),        32'd0);

    // Reset during the second CALIB attempt
    at(11); en_i = 1'b1; start();
    at(20); chk("mr_state_c20", 32'(state_o),       32'd4);
            chk("mr_retry_c20", 32'(retry_count_o), 32'd1);
            reset_n_i = 1'b0;
    at(21); chk("mr_io",    32'(asic_io_en_o),   32'd0);
            chk("mr_core",  32'(asic_core_en_o), 32'd0);
            chk("mr_pot",   32'(dig_pot_nrst_o), 32'd0);
            chk("mr_lrst",  32'(link_reset_o),   32'd1);
            chk("mr_state", 32'(state_o),        32'd0);
            chk("mr_retry", 32'(retry_count_o),  32'd0);
            reset_n_i = 1'b1; en_i = 1'b0;
    at(23); chk("mr_off_c23", 32'(state_o),      32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
